// File: rtl/alu_acc_seq_pkg.sv
// alu_acc_seq_pkg
// Shared definitions for the accumulator command sequencer. It holds the ALU
// opcode constants, the sequencer FSM state type, the width of a packed
// command word, and a helper function. The helper tells which opcodes carry
// a meaningful ALU carry.
package alu_acc_seq_pkg;

  // ALU opcode map (4-bit, 16 operations)
  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_AND     = 4'b0010;
  localparam logic [3:0] OP_OR      = 4'b0011;
  localparam logic [3:0] OP_XOR     = 4'b0100;
  localparam logic [3:0] OP_NAND    = 4'b0101;
  localparam logic [3:0] OP_NOR     = 4'b0110;
  localparam logic [3:0] OP_XNOR    = 4'b0111;
  localparam logic [3:0] OP_ADDC    = 4'b1000;
  localparam logic [3:0] OP_SUBB    = 4'b1001;
  localparam logic [3:0] OP_SHL     = 4'b1010;
  localparam logic [3:0] OP_SHR     = 4'b1011;
  localparam logic [3:0] OP_ROL     = 4'b1100;
  localparam logic [3:0] OP_ROR     = 4'b1101;
  localparam logic [3:0] OP_NOT     = 4'b1110;
  localparam logic [3:0] OP_NOT_NOT = 4'b1111;

  // Packed command word: {load, opcode[3:0], operand[7:0]}
  localparam int CMD_W = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Only the add/subtract family produces a carry worth reporting.
  function automatic logic has_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDC) || (op == OP_SUBB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo
// Small synchronous command FIFO that uses a count to track full and empty.
// The ready output is registered and equals !full. While rst is high, ready
// is held low.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, push_data  write request and data (accepted only while ready)
//   pop              read request; advances the head (ignored when empty)
//   pop_data         current head entry (valid while !empty)
//   empty            no entries stored
//   ready            registered !full; a push is accepted only when high
module alu_cmd_fifo
  import alu_acc_seq_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push_ok;
  logic             pop_ok;

  // A push is gated by the registered ready. For that reason a full FIFO
  // refuses a push even on an edge where it is also popping.
  assign push_ok    = push & ready;
  assign pop_ok     = pop & (count != '0);
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);
  assign empty      = (count == '0);
  assign pop_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      ready <= (count_next != FULL_COUNT);
    end
  end

  // Storage is not reset. Entries become meaningless once count is cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_acc_seq.sv
// alu_acc_seq
// Accumulator command sequencer in front of an external 8-bit combinational
// ALU. A command is {load, opcode, operand}. When issued, the command drives
// the ALU with bin1 = acc and bin2 = operand. One cycle later the block
// captures either the ALU result or the load value into acc and into the
// response registers.
// Build option ALU_ACC_SEQ_FIFO_EN adds a DEPTH-entry command FIFO. With the
// FIFO, latency is 2 cycles and a new command can chain from RESP. Without it,
// cmd_ready is high only in IDLE and latency is 1 cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command stream handshake
//   cmd_load                  1: load cmd_operand into acc, ALU bypassed
//   cmd_opcode, cmd_operand   ALU opcode, bin2 or load value
//   bin1, bin2, opcode        registered ALU inputs
//   alu_out, alu_carry        ALU result inputs
//   res_valid/res_ready       result stream handshake
//   res_data, res_carry, res_zero  result and flags, held until accepted
//   acc                       current accumulator
module alu_acc_seq
  import alu_acc_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [3:0] cmd_opcode,
  input  logic [7:0] cmd_operand,
  output logic [7:0] bin1,
  output logic [7:0] bin2,
  output logic [3:0] opcode,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       res_zero,
  output logic [7:0] acc
);

  state_t     state;
  state_t     state_next;
  logic       issue;
  logic       cmd_avail;
  logic       chain_avail;
  logic       iss_load;
  logic [3:0] iss_opcode;
  logic [7:0] iss_operand;
  logic       load_q;

`ifdef ALU_ACC_SEQ_FIFO_EN
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_empty;
  logic             fifo_ready;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid & fifo_ready),
    .push_data ({cmd_load, cmd_opcode, cmd_operand}),
    .pop       (issue),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .ready     (fifo_ready)
  );

  assign cmd_ready   = fifo_ready;
  assign cmd_avail   = !fifo_empty;
  assign chain_avail = !fifo_empty;
  assign {iss_load, iss_opcode, iss_operand} = fifo_rdata;
`else
  // Without a FIFO the depth has no meaning.
  localparam int depth_unused = DEPTH;

  // Commands go straight into the issue registers. The block can therefore
  // accept a command only while idle and out of reset.
  assign cmd_ready   = (state == IDLE) && !rst;
  assign cmd_avail   = cmd_valid & cmd_ready;
  assign chain_avail = 1'b0;
  assign {iss_load, iss_opcode, iss_operand} = {cmd_load, cmd_opcode, cmd_operand};
`endif

  assign res_valid = (state == RESP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and issue strobe. An issue pops the FIFO (when present) and
  // loads the ALU input registers on the same edge.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_avail) begin
          issue      = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (res_ready) begin
          if (chain_avail) begin
            issue      = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. An issue never happens in EXEC, so bin1 always picks up the
  // accumulator value written by the previous command.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin1      <= '0;
      bin2      <= '0;
      opcode    <= '0;
      load_q    <= 1'b0;
      acc       <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
    end else begin
      if (issue) begin
        bin1   <= acc;
        bin2   <= iss_operand;
        opcode <= iss_load ? 4'h0 : iss_opcode;
        load_q <= iss_load;
      end
      if (state == EXEC) begin
        if (load_q) begin
          acc       <= bin2;
          res_data  <= bin2;
          res_carry <= 1'b0;
          res_zero  <= (bin2 == 8'h00);
        end else begin
          acc       <= alu_out;
          res_data  <= alu_out;
          res_carry <= alu_carry & has_carry(opcode);
          res_zero  <= (alu_out == 8'h00);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
// tb_alu_acc_seq
// Self-checking bench for alu_acc_seq. The bench plays the parent and
// supplies a behavioural 16-opcode ALU. Expected results come from directed
// vector tables and from a queue-based reference model that applies command
// rules to an abstract accumulator. Build-specific sequences are selected by
// ALU_ACC_SEQ_FIFO_EN.
module tb_alu_acc_seq;

`ifdef ALU_ACC_SEQ_FIFO_EN
  localparam int LATENCY  = 2;
  localparam int RST_CMDS = 4;
`else
  localparam int LATENCY  = 1;
  localparam int RST_CMDS = 1;
`endif

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_operand;
  logic [7:0] bin1;
  logic [7:0] bin2;
  logic [3:0] opcode;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic [7:0] acc;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic       zero;
  } res_t;

  typedef struct {
    logic       ld;
    logic [3:0] op;
    logic [7:0] opd;
    logic [7:0] data;
    logic       carry;
    logic       zero;
  } vec_t;

  res_t       exp_q[$];
  logic [7:0] model_acc;

  alu_acc_seq #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_opcode  (cmd_opcode),
    .cmd_operand (cmd_operand),
    .bin1        (bin1),
    .bin2        (bin2),
    .opcode      (opcode),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_carry   (res_carry),
    .res_zero    (res_zero),
    .acc         (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU returning {carry, result}. Non-arithmetic opcodes drive
  // a junk carry so that the sequencer's masking is visible.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    case (op)
      4'h0: w = {1'b0, a} + {1'b0, b};
      4'h1: w = {(a < b), 8'(a - b)};
      4'h2: w = {1'b1, a & b};
      4'h3: w = {1'b1, a | b};
      4'h4: w = {1'b1, a ^ b};
      4'h5: w = {1'b1, ~(a & b)};
      4'h6: w = {1'b1, ~(a | b)};
      4'h7: w = {1'b1, ~(a ^ b)};
      4'h8: w = {1'b0, a} + {1'b0, b} + 9'd1;
      4'h9: w = {({1'b0, a} < ({1'b0, b} + 9'd1)), 8'(a - b - 8'd1)};
      4'hA: w = {a[7], a[6:0], 1'b0};
      4'hB: w = {a[0], 1'b0, a[7:1]};
      4'hC: w = {1'b1, a[6:0], a[7]};
      4'hD: w = {1'b1, a[0], a[7:1]};
      4'hE: w = {1'b1, ~a};
      default: w = {1'b1, a};
    endcase
    return w;
  endfunction

  always_comb {alu_carry, alu_out} = alu_fn(opcode, bin1, bin2);

  // Reference model: each accepted command produces one expected result, in
  // acceptance order, based on the model's own accumulator.
  function automatic void modelPush(input logic ld, input logic [3:0] op, input logic [7:0] opd);
    logic [8:0] w;
    res_t r;
    if (ld) begin
      r.data  = opd;
      r.carry = 1'b0;
    end else begin
      w       = alu_fn(op, model_acc, opd);
      r.data  = w[7:0];
      r.carry = w[8] && (op inside {4'h0, 4'h1, 4'h8, 4'h9});
    end
    r.zero    = (r.data == 8'h00);
    model_acc = r.data;
    exp_q.push_back(r);
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  function automatic void failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s at t=%0t: bound expired", name, $time);
  endfunction

  // Offers one command and waits (bounded) for it to be accepted. The call
  // starts and ends 1 time unit after a rising edge.
  task automatic applyStimulus(input logic ld, input logic [3:0] op, input logic [7:0] opd);
    int w = 0;
    cmd_valid   = 1'b1;
    cmd_load    = ld;
    cmd_opcode  = op;
    cmd_operand = opd;
    while (!cmd_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!cmd_ready) begin
      failNow("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    modelPush(ld, op, opd);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Waits for one result, compares it against the model, and accepts it.
  task automatic receiveResult(input string tag, output res_t got);
    int w = 0;
    res_t e;
    got.data  = '0;
    got.carry = 1'b0;
    got.zero  = 1'b0;
    res_ready = 1'b1;
    while (!res_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!res_valid) begin
      failNow({tag, "_timeout"});
      res_ready = 1'b0;
      return;
    end
    got.data  = res_data;
    got.carry = res_carry;
    got.zero  = res_zero;
    if (exp_q.size() == 0) begin
      failNow({tag, "_unexpected"});
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_data"},  32'(res_data),  32'(e.data));
      checkOutput({tag, "_carry"}, 32'(res_carry), 32'(e.carry));
      checkOutput({tag, "_zero"},  32'(res_zero),  32'(e.zero));
      checkOutput({tag, "_acc"},   32'(acc),       32'(e.data));
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog at t=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    res_t got;
    int   lat;
    int   seen;

    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0;
    cmd_opcode = '0; cmd_operand = '0; res_ready = 1'b0;
    model_acc = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 0);
    checkOutput("rst_res_valid", 32'(res_valid), 0);
    checkOutput("rst_acc",       32'(acc),       0);
    checkOutput("rst_bin1",      32'(bin1),      0);
    checkOutput("rst_bin2",      32'(bin2),      0);
    checkOutput("rst_opcode",    32'(opcode),    0);
    checkOutput("rst_res_data",  32'(res_data),  0);
    checkOutput("rst_res_carry", 32'(res_carry), 0);
    checkOutput("rst_res_zero",  32'(res_zero),  0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Directed vector table
    vecs.push_back(vec_t'{1'b1, 4'h0, 8'h0D, 8'h0D, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h0, 8'hF1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 4'h0, 8'h0D, 8'h0D, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h1, 8'hF1, 8'h1C, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 4'h0, 8'hFF, 8'hFF, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h0, 8'h01, 8'h00, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h2, 8'hF1, 8'h00, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 4'h5, 8'h80, 8'h80, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'hA, 8'h00, 8'h00, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 4'h0, 8'hFF, 8'hFF, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h8, 8'h00, 8'h00, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b1, 4'h0, 8'h01, 8'h01, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h9, 8'h01, 8'hFF, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'hF, 8'h55, 8'hFF, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h4, 8'h0F, 8'hF0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h1, 8'h01, 8'hFF, 1'b1, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ld, vecs[i].op, vecs[i].opd);
      receiveResult($sformatf("vec%0d", i), got);
      checkOutput($sformatf("vec%0d_tbl_data", i),  32'(got.data),  32'(vecs[i].data));
      checkOutput($sformatf("vec%0d_tbl_carry", i), 32'(got.carry), 32'(vecs[i].carry));
      checkOutput($sformatf("vec%0d_tbl_zero", i),  32'(got.zero),  32'(vecs[i].zero));
    end

    // Latency from handshake edge to res_valid
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_opcode = 4'h0; cmd_operand = 8'h3C;
    checkOutput("lat_cmd_ready", 32'(cmd_ready), 1);
    modelPush(1'b1, 4'h0, 8'h3C);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
`ifndef ALU_ACC_SEQ_FIFO_EN
    checkOutput("nofifo_ready_after_hs", 32'(cmd_ready), 0);
`endif
    lat = 0;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(LATENCY));
    receiveResult("lat_res", got);

`ifdef ALU_ACC_SEQ_FIFO_EN
    // Stall: six commands offered back to back while results are held off
    begin
      logic [7:0] opds [6];
      int idx;
      int got_n;
      int last;
      logic [7:0] snap;
      opds[0] = 8'h10; opds[1] = 8'h01; opds[2] = 8'h02;
      opds[3] = 8'h03; opds[4] = 8'h04; opds[5] = 8'h05;
      idx = 0;
      res_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
        logic acc_now;
        cmd_valid   = 1'b1;
        cmd_load    = (idx == 0);
        cmd_opcode  = 4'h0;
        cmd_operand = opds[idx];
        acc_now = cmd_ready;
        if (acc_now) modelPush(idx == 0, 4'h0, opds[idx]);
        @(posedge clk); #1;
        if (acc_now && idx < 5) idx++;
        else if (acc_now) idx = 6;
      end
      checkOutput("stall_accepted", 32'(idx), 5);
      checkOutput("stall_cmd_ready", 32'(cmd_ready), 0);
      cmd_valid = 1'b0;
      snap = res_data;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("stall_res_valid", 32'(res_valid), 1);
      checkOutput("stall_res_stable", 32'(res_data), 32'(snap));
      checkOutput("stall_res_first", 32'(res_data), 8'h10);
      res_ready = 1'b1;
      got_n = 0;
      last  = 0;
      for (int c = 0; c < 40 && got_n < 5; c++) begin
        if (res_valid) begin
          res_t e;
          if (exp_q.size() == 0) begin
            failNow("drain_unexpected");
          end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("drain%0d_data", got_n), 32'(res_data), 32'(e.data));
          end
          if (got_n > 0) checkOutput($sformatf("drain%0d_gap", got_n), 32'(cyc - last), 2);
          last = cyc;
          got_n++;
        end
        @(posedge clk); #1;
      end
      res_ready = 1'b0;
      checkOutput("drain_count", 32'(got_n), 5);
    end
`else
    // Window between handshake and RESP handshake: nothing is accepted
    applyStimulus(1'b1, 4'h0, 8'h42);
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_opcode = 4'h0; cmd_operand = 8'h99;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (cmd_ready) seen++;
      @(posedge clk); #1;
    end
    checkOutput("window_ready_seen", 32'(seen), 0);
    cmd_valid = 1'b0;
    receiveResult("window_res", got);
    checkOutput("window_idle_ready", 32'(cmd_ready), 1);
    checkOutput("window_idle_valid", 32'(res_valid), 0);
`endif

    // Reset while a result is pending and commands are queued
    res_ready = 1'b0;
    applyStimulus(1'b1, 4'h0, 8'h77);
    for (int i = 1; i < RST_CMDS; i++) applyStimulus(1'b0, 4'h0, 8'(i));
    lat = 0;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("pre_rst_res_valid", 32'(res_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rst_res_valid", 32'(res_valid), 0);
    checkOutput("mid_rst_acc",       32'(acc),       0);
    checkOutput("mid_rst_bin1",      32'(bin1),      0);
    checkOutput("mid_rst_bin2",      32'(bin2),      0);
    checkOutput("mid_rst_opcode",    32'(opcode),    0);
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    model_acc = '0;
    exp_q.delete();
    @(posedge clk); #1;
    checkOutput("mid_rst_release_ready", 32'(cmd_ready), 1);
    res_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (res_valid) seen++;
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    checkOutput("no_stale_results", 32'(seen), 0);
    applyStimulus(1'b0, 4'h0, 8'h5A);
    receiveResult("post_rst_add", got);
    checkOutput("post_rst_add_tbl", 32'(got.data), 8'h5A);

    // Randomized traffic with random result back-pressure
    begin
      int n_cmds;
      int got_n;
      n_cmds = 80;
      got_n  = 0;
      fork
        begin
          for (int i = 0; i < n_cmds; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
              @(posedge clk); #1;
            end
            applyStimulus($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 8'($urandom));
          end
        end
        begin
          for (int c = 0; c < 5000 && got_n < n_cmds; c++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            if (res_valid && res_ready) begin
              res_t e;
              if (exp_q.size() == 0) begin
                failNow("rand_unexpected");
              end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("rand%0d_data", got_n),  32'(res_data),  32'(e.data));
                checkOutput($sformatf("rand%0d_carry", got_n), 32'(res_carry), 32'(e.carry));
                checkOutput($sformatf("rand%0d_zero", got_n),  32'(res_zero),  32'(e.zero));
              end
              got_n++;
            end
            @(posedge clk); #1;
          end
          res_ready = 1'b0;
        end
      join
      checkOutput("rand_count", 32'(got_n), 32'(n_cmds));
      checkOutput("rand_queue_empty", 32'(exp_q.size()), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Accumulator-based command sequencer sitting directly upstream of the 8-bit, 16-opcode combinational ALU. It accepts {opcode, operand} commands over a valid/ready stream and queues them. It drives the ALU with bin1 = accumulator and bin2 = operand, then captures the ALU result and carry back into the accumulator. Each result is returned with carry and zero flags over a second valid/ready stream.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries, power of two, ≥2; used only when the FIFO is compiled in.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_load  in  1  1 loads cmd_operand into the accumulator and bypasses the ALU.
- cmd_opcode  in  4  ALU opcode; ignored when cmd_load=1.
- cmd_operand  in  8  bin2 value, or load value.
- bin1  out  8  to ALU; registered accumulator copy.
- bin2  out  8  to ALU; registered operand.
- opcode  out  4  to ALU; registered.
- alu_out  in  8  ALU result.
- alu_carry  in  1  ALU carry.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  result, which equals the new accumulator value.
- res_carry  out  1  carry flag.
- res_zero  out  1  1 when res_data==0.
- acc  out  8  current accumulator.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE→EXEC: taken when a command is available (FIFO non-empty). That edge pops the command and loads bin1←acc, bin2←operand, opcode←cmd_opcode (0 if load), and the load flag.
- EXEC→RESP: taken unconditionally on the next edge.
  - For an ALU command, acc←alu_out and res_data←alu_out.
  - For a load command, acc←operand, res_data←operand, res_carry←0.
- res_carry←alu_carry only for opcodes 0000, 0001, 1000, 1001. It is forced to 0 for every other opcode, because the ALU carry is meaningless there.
- res_zero←(captured value==0).
- RESP: res_valid=1. res_data, res_carry and res_zero are held stable until res_valid & res_ready.
- On the RESP handshake edge:
  - if a command is available → EXEC, with the pop done on that same edge;
  - otherwise → IDLE.
- Accumulator arithmetic is 8-bit modular; wrap-around is signalled only via carry.
- FIFO:
  - cmd_ready = !full, registered.
  - A push while full is never accepted, even when a pop occurs on the same edge.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Order is strictly FIFO.
- Reset, including mid-operation:
  - Next state IDLE; FIFO emptied and pending commands discarded.
  - acc, bin1, bin2, opcode, res_data, res_carry, res_zero = 0.
  - res_valid = 0; cmd_ready = 0 while rst is high, 1 on the first cycle after.

## Timing
- ALU is purely combinational. alu_out is sampled at the end of the EXEC cycle, one cycle after bin1/bin2/opcode update.
- FIFO build: cmd handshake at edge E into an empty, idle block → EXEC after E+1 → res_valid high after E+2. Latency is 2 cycles.
- Throughput with res_ready held at 1: one result every 2 cycles.
- Accumulator dependence is inherent. Command N+1 always sees the acc written by command N.

## Configuration
- ALU_ACC_SEQ_FIFO_EN defined: DEPTH-entry command FIFO as described above.
- ALU_ACC_SEQ_FIFO_EN undefined: no FIFO.
  - cmd_ready = (state==IDLE), combinational from state.
  - A handshake at edge E loads the issue registers directly and enters EXEC.
  - res_valid is high after E+1, giving 1-cycle latency.
  - RESP handshake always → IDLE.

## Structure
- Shared package holds:
  - opcode constants OP_ADD…OP_NOT_NOT (0000–1111);
  - FSM state typedef;
  - helper function has_carry(opcode) covering 0000/0001/1000/1001.
- One natural sub-module, alu_cmd_fifo: a synchronous FIFO with count-based full/empty, instantiated only under ALU_ACC_SEQ_FIFO_EN.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Load 0x0D, then ADD (0000) operand 0xF1 → second result: res_data=0xFE, carry=0, zero=0, acc=0xFE.
- Load 0x0D, then SUB (0001) operand 0xF1 → res_data=0x1C, carry=1; acc=0x1C.
- Load 0xFF, then ADD operand 0x01 → res_data=0x00, carry=1, zero=1. Then AND (0010) operand 0xF1 → res_data=0x00, carry=0, zero=1.
- FIFO build, res_ready held at 0, six back-to-back commands offered:
  - exactly 5 accepted (1 in flight + 4 queued);
  - cmd_ready=0 thereafter;
  - res_data stable while stalled;
  - releasing res_ready drains the results in order, one every 2 cycles.
- Assert rst for one cycle while in RESP with 3 commands queued:
  - next cycle res_valid=0, acc=0, bin1/bin2/opcode=0;
  - cmd_ready=1 after release;
  - no stale results ever emerge.
- Non-FIFO build: cmd_ready=0 from handshake until the RESP handshake; a command offered during that window is not accepted; latency is 1 cycle.
